// File: rtl/seg_text_writer.sv
//------------------------------------------------------------------------------
// seg_text_writer: Morse character sink that builds a right-entry 8-digit
// seven-segment text buffer with backspace/clear and a blinking cursor.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seg_text_writer #(
  parameter int BLINK_DIV = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        char_valid,
  input  logic [5:0]  char_code,
  input  logic        cmd_bksp,
  input  logic        cmd_clear,
  input  logic        cursor_en,
  output logic        ready,
  output logic [63:0] seg_data,
  output logic [3:0]  char_count,
  output logic        overflow
);

  localparam int              CNT_W   = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [3:0]       DIGITS  = 4'd8;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOOKUP = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [5:0]       code_q, code_d;
  logic [63:0]      buf_q, buf_d;
  logic [3:0]       count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             live_q, live_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             phase_q, phase_d;

  logic [7:0]       glyph;
  logic             cursor_dp;

  // Segment byte ordering is a,b,c,d,e,f,g,dp from MSB to LSB; dp always 0.
  function automatic logic [7:0] glyph_of(input logic [5:0] c);
    logic [7:0] g;
    case (c)
      6'd0:  g = 8'hFC;
      6'd1:  g = 8'h60;
      6'd2:  g = 8'hDA;
      6'd3:  g = 8'hF2;
      6'd4:  g = 8'h66;
      6'd5:  g = 8'hB6;
      6'd6:  g = 8'hBE;
      6'd7:  g = 8'hE0;
      6'd8:  g = 8'hFE;
      6'd9:  g = 8'hF6;
      6'd10: g = 8'hEE;
      6'd11: g = 8'h3E;
      6'd12: g = 8'h9C;
      6'd13: g = 8'h7A;
      6'd14: g = 8'h9E;
      6'd15: g = 8'h8E;
      6'd16: g = 8'hBC;
      6'd17: g = 8'h6E;
      6'd18: g = 8'h0C;
      6'd19: g = 8'h78;
      6'd20: g = 8'hAE;
      6'd21: g = 8'h1C;
      6'd22: g = 8'hD4;
      6'd23: g = 8'h2A;
      6'd24: g = 8'h3A;
      6'd25: g = 8'hCE;
      6'd26: g = 8'hE6;
      6'd27: g = 8'h0A;
      6'd28: g = 8'hB6;
      6'd29: g = 8'h1E;
      6'd30: g = 8'h7C;
      6'd31: g = 8'h38;
      6'd32: g = 8'h56;
      6'd33: g = 8'h6C;
      6'd34: g = 8'h76;
      6'd35: g = 8'hDA;
      6'd36: g = 8'h00;
      default: g = 8'h02;
    endcase
    return g;
  endfunction

  assign glyph = glyph_of(code_q);

  // live_q holds ready low until the first edge after reset release.
  assign ready      = (state_q == S_IDLE) & live_q;
  assign cursor_dp  = cursor_en & phase_q & (count_q < DIGITS);
  assign seg_data   = {buf_q[63:1], buf_q[0] | cursor_dp};
  assign char_count = count_q;
  assign overflow   = ovf_q;

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    buf_d       = buf_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    live_d      = 1'b1;
    blink_cnt_d = blink_cnt_q + CNT_ONE;
    phase_d     = phase_q;

    if (blink_cnt_q == CNT_MAX) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end

    case (state_q)
      S_IDLE: begin
        if (ready) begin
          if (cmd_clear) begin
            buf_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
          end else if (cmd_bksp) begin
            if (count_q != 4'd0) begin
              buf_d   = {8'h00, buf_q[63:8]};
              count_d = count_q - 4'd1;
            end
          end else if (char_valid) begin
            code_d  = char_code;
            state_d = S_LOOKUP;
          end
        end
      end
      S_LOOKUP: begin
        // At full occupancy the oldest digit scrolls out and the count holds.
        buf_d = {buf_q[55:0], glyph};
        if (count_q == DIGITS) begin
          ovf_d = 1'b1;
        end else begin
          count_d = count_q + 4'd1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      code_q      <= '0;
      buf_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      live_q      <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      buf_q       <= buf_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      live_q      <= live_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

endmodule

`default_nettype wire

// File: doc/seg_text_writer.md
Name: seg_text_writer

Overview:
- Producer side of the 8-digit multiplexed seven-segment display: accepts decoded Morse characters one at a time over a valid/ready handshake.
- Converts each character to a segment glyph and maintains a right-entry scrolling text buffer.
- Drives the 64-bit segment-pattern bus that the display scanner consumes.
- Also handles backspace and clear commands, and a blinking cursor on the newest digit.

Parameters:
- BLINK_DIV, 50_000_000, clk cycles per cursor-blink half period (must be >= 2)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-low; all registers clear while rst=0
- char_valid  input  1  char_code is offered this cycle
- char_code  input  6  0-9 = digits '0'-'9'; 10-35 = letters A-Z; 36 = space; 37-63 = unknown
- cmd_bksp  input  1  backspace request, single-cycle pulse
- cmd_clear  input  1  clear request, single-cycle pulse
- cursor_en  input  1  1 = blink dp of digit 0 while the buffer is not full
- ready  output  1  block can take a char or command this cycle
- seg_data  output  64  glyphs; [7:0] = rightmost digit 0 (newest), [63:56] = leftmost digit 7
- char_count  output  4  number of occupied digits, 0-8
- overflow  output  1  sticky: a character was pushed while 8 digits were occupied

Behaviour:
- Reset values: seg_data=0, char_count=0, overflow=0, ready=0.
  - ready goes to 1 on the first clock edge after rst releases.
  - Pipeline state is IDLE; blink counter=0; blink phase=0.
- Glyph encoding:
  - Segment byte bit7..bit0 = a,b,c,d,e,f,g,dp; active-high.
  - Digits 0-9: FC 60 DA F2 66 B6 BE E0 FE F6.
  - Letters A-Z: EE 3E 9C 7A 9E 8E BC 6E 0C 78 AE 1C D4 2A 3A CE E6 0A B6 1E 7C 38 56 6C 76 DA.
  - Space (36) = 00; codes 37-63 = 02 ("-").
  - Stored glyphs always have dp=0.
- ready is combinational: ready = (state==IDLE) & rst released.
- Accept rules:
  - A command or character is accepted only in a cycle with ready=1.
  - Priority on that cycle: cmd_clear > cmd_bksp > char_valid. Lower-priority inputs on the same cycle are dropped, not queued.
  - Inputs arriving with ready=0 are ignored; the source must hold char_valid until it sees ready=1.
- State machine IDLE -> LOOKUP -> IDLE (character path only):
  - IDLE: a character accept latches char_code into code_q, then goes to LOOKUP. ready=0 during LOOKUP.
  - LOOKUP: on the next edge, seg_data <= {seg_data[55:0], glyph(code_q)}. Then:
    - if char_count==8, set overflow=1;
    - otherwise char_count+1;
    - return to IDLE.
  - Latency: seg_data is updated 2 edges after the accept edge. The next accept is possible on the cycle after the update.
- Commands (single cycle, stay in IDLE):
  - Clear: seg_data=0, char_count=0, overflow=0.
  - Backspace:
    - If char_count>0: seg_data <= {8'h00, seg_data[63:8]}, char_count-1.
    - If char_count==0: no change.
    - Backspace never clears overflow.
- Overflow and wrap: at 8 occupied digits a new character shifts out digit 7 (oldest) and char_count stays 8; there is no wrap to 0.
- Cursor:
  - The blink counter counts 0..BLINK_DIV-1 and wraps; the blink phase toggles on each wrap. The counter runs continuously from reset.
  - The cursor dp is ORed into output bit seg_data[0] only. It is never stored in the buffer.
  - Cursor dp = cursor_en & phase & (char_count<8).
- Reset mid-operation: rst low during LOOKUP aborts the pending character. Nothing is written; all state returns to reset values.

Test Plan:
- Reset release, cursor_en=0 → seg_data=0, char_count=0, ready=1 on the first edge after release.
- Push code 10 ('A'): seg_data=0x..EE two edges after accept. Then code 3: seg_data[15:0]=0xEEF2, char_count=2. ready=0 exactly one cycle per character.
- Push 9 characters, codes 0..8 → seg_data=0x60DAF266B6BEE0FE, char_count=8, overflow=1.
  - Then backspace → seg_data=0x0060DAF266B6BEE0, char_count=7, overflow still 1.
  - Then clear → all zero, overflow=0.
- Same-cycle cmd_clear+cmd_bksp+char_valid with 3 chars stored → buffer cleared, char not taken. Backspace at count 0 → seg_data unchanged. Code 50 → glyph 02.
- BLINK_DIV=4, cursor_en=1, count=1 → seg_data[0] toggles every 4 cycles. At count=8 or cursor_en=0, seg_data[0]=0.
- Assert rst low during LOOKUP → after release, seg_data=0, char_count=0, and the aborted char never appears.
